// File: rtl/router_input_unit.sv
// Per-port mesh router input stage: flit FIFO, XY route computation, switch request.
// Optional dropped-flit counter (err_cnt port) enabled by defining ROUTER_IN_ERR_CNT_EN.
module router_input_unit #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PORT_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cfg_xaddr,
  input  logic [7:0]  cfg_yaddr,
  input  logic [18:0] in_flit,
  output logic        in_ready,
  output logic [18:0] out_flit,
  output logic [2:0]  out_port,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  state
`ifdef ROUTER_IN_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] TypeHead = 2'd0;
  localparam logic [1:0] TypeTail = 2'd1;
  localparam logic [1:0] TypeNone = 2'd3;

  localparam logic [2:0] PortLocal = 3'd0;
  localparam logic [2:0] PortNorth = 3'd1;
  localparam logic [2:0] PortSouth = 3'd2;
  localparam logic [2:0] PortEast  = 3'd3;
  localparam logic [2:0] PortWest  = 3'd4;
  localparam logic [2:0] PortNone  = 3'd5;

  localparam logic [18:0] InvalidFlit = 19'h30000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRouting = 2'd1,
    StActive  = 2'd2
  } state_e;

  logic [18:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [2:0]    route_q, route_d;

  logic        push, pop, empty;
  logic        drop_in, drop_orphan;
  logic [1:0]  in_type, head_type;
  logic [18:0] head_flit;
  logic [7:0]  dst_x, dst_y;

  // Space check uses only the registered count, so a same-cycle pop never frees a slot.
  assign in_type   = in_flit[17:16];
  assign in_ready  = count_q < CW'(DEPTH);
  assign push      = in_flit[18] & in_ready & (in_type != TypeNone);
  assign drop_in   = in_flit[18] & in_ready & (in_type == TypeNone);
  assign empty     = (count_q == '0);
  assign head_flit = mem_q[rd_ptr_q];
  assign head_type = head_flit[17:16];
  assign dst_x     = head_flit[15:8];
  assign dst_y     = head_flit[7:0];

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    pop         = 1'b0;
    drop_orphan = 1'b0;
    out_valid   = 1'b0;
    out_flit    = InvalidFlit;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head_type == TypeHead) begin
            state_d = StRouting;
          end else begin
            pop         = 1'b1;
            drop_orphan = 1'b1;
          end
        end
      end
      StRouting: begin
        // X first, then Y; unsigned 8-bit compares.
        if (dst_x > cfg_xaddr) begin
          route_d = PortEast;
        end else if (dst_x < cfg_xaddr) begin
          route_d = PortWest;
        end else if (dst_y > cfg_yaddr) begin
          route_d = PortSouth;
        end else if (dst_y < cfg_yaddr) begin
          route_d = PortNorth;
        end else begin
          route_d = PortLocal;
        end
        state_d = StActive;
      end
      StActive: begin
        out_valid = !empty;
        if (!empty) begin
          out_flit = head_flit;
        end
        pop = out_valid & out_ready;
        if (pop && (head_type == TypeTail)) begin
          state_d = StIdle;
          route_d = PortNone;
        end
      end
      default: begin
        state_d = StIdle;
        route_d = PortNone;
      end
    endcase
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      route_q  <= PortNone;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_flit;
    end
  end

  assign out_port = route_q;
  assign state    = state_q;

  logic [2:0] unused_port_id;
  assign unused_port_id = 3'(PORT_ID);

`ifdef ROUTER_IN_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  // Both drop sources can fire together, so the step may be 2; saturate at 255.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 9'(drop_in) + 9'(drop_orphan);
    err_cnt_d = (err_sum > 9'd255) ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_drops;
  assign unused_drops = drop_in ^ drop_orphan;
`endif

endmodule
